// File: rtl/fpu_apu_arbiter_pkg.sv
// Shared types for the APU-attached FPU arbiter: FSM state and the request payload.
// The payload widths here are the defaults the top-level parameters start from.
package fpu_apu_arbiter_pkg;

  localparam int unsigned NARGS    = 3;
  localparam int unsigned WOP      = 6;
  localparam int unsigned NDSFLAGS = 15;
  localparam int unsigned NUSFLAGS = 5;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_e;

  typedef struct packed {
    logic [NARGS-1:0][31:0] operands;
    logic [WOP-1:0]         op;
    logic [NDSFLAGS-1:0]    flags;
  } apu_req_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first asserted request at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] id,
  output logic            valid
);

  logic [ID_W-1:0] idx;

  always_comb begin
    id    = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = ID_W'((32'(ptr) + i) % N);
      if (!valid && req[idx]) begin
        valid = 1'b1;
        id    = idx;
      end
    end
  end

endmodule

// File: rtl/fpu_apu_arbiter.sv
// Shares one untagged APU FPU among NB_REQ requesters with a single outstanding
// operation; the result is routed back to the requester that owns it.
module fpu_apu_arbiter
  import fpu_apu_arbiter_pkg::*;
#(
  parameter int unsigned NB_REQ       = 4,
  parameter int unsigned APU_NARGS    = NARGS,
  parameter int unsigned APU_WOP      = WOP,
  parameter int unsigned APU_NDSFLAGS = NDSFLAGS,
  parameter int unsigned APU_NUSFLAGS = NUSFLAGS,
  parameter int unsigned ID_W         = $clog2(NB_REQ)
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic [NB_REQ-1:0]                          req_i,
  output logic [NB_REQ-1:0]                          gnt_o,
  input  logic [NB_REQ-1:0][APU_NARGS-1:0][31:0]     operands_i,
  input  logic [NB_REQ-1:0][APU_WOP-1:0]             op_i,
  input  logic [NB_REQ-1:0][APU_NDSFLAGS-1:0]        flags_i,
  output logic [NB_REQ-1:0]                          rvalid_o,
  output logic [31:0]                                rdata_o,
  output logic [APU_NUSFLAGS-1:0]                    rflags_o,
  output logic                                       apu_req_o,
  input  logic                                       apu_gnt_i,
  output logic [APU_NARGS-1:0][31:0]                 apu_operands_o,
  output logic [APU_WOP-1:0]                         apu_op_o,
  output logic [APU_NDSFLAGS-1:0]                    apu_flags_o,
  input  logic                                       apu_rvalid_i,
  input  logic [31:0]                                apu_rdata_i,
  input  logic [APU_NUSFLAGS-1:0]                    apu_rflags_i,
  output logic                                       err_o
);

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [ID_W-1:0] win_q, win_d;
  logic            err_q, err_d;

  logic [ID_W-1:0] pick_id, issue_id;
  logic            pick_valid, issue_en, fire;
  apu_req_t        payload [NB_REQ];
  apu_req_t        sel;

  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
    return (id == ID_W'(NB_REQ - 1)) ? '0 : id + 1'b1;
  endfunction

  rr_pick #(
    .N    (NB_REQ),
    .ID_W (ID_W)
  ) u_rr_pick (
    .req   (req_i),
    .ptr   (rr_ptr_q),
    .id    (pick_id),
    .valid (pick_valid)
  );

  for (genvar k = 0; k < NB_REQ; k++) begin : g_payload
    assign payload[k] = '{operands: operands_i[k], op: op_i[k], flags: flags_i[k]};
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    win_d    = win_q;
    err_d    = err_q;
    gnt_o    = '0;
    rvalid_o = '0;
    issue_en = 1'b0;
    issue_id = pick_id;

    // Work is offered from IDLE, from a locked winner, or straight after a result returns.
    case (state_q)
      IDLE:    issue_en = pick_valid;
      ISSUE: begin
        issue_en = 1'b1;
        issue_id = win_q;
      end
      WAIT:    issue_en = apu_rvalid_i && pick_valid;
      default: ;
    endcase

    // Outputs are forced quiet while reset is held, independent of the inputs.
    issue_en = issue_en && rst_ni;
    fire     = issue_en && apu_gnt_i;

    if (state_q == WAIT) begin
      if (apu_rvalid_i && rst_ni) rvalid_o[owner_q] = 1'b1;
    end else if (fire && apu_rvalid_i) begin
      rvalid_o[issue_id] = 1'b1;
    end

    if (state_q != WAIT && apu_rvalid_i && !fire) err_d = 1'b1;

    if (fire) begin
      gnt_o[issue_id] = 1'b1;
      owner_d         = issue_id;
      rr_ptr_d        = next_ptr(issue_id);
      // A same-cycle result outside WAIT completes the operation immediately.
      state_d         = (state_q != WAIT && apu_rvalid_i) ? IDLE : WAIT;
    end else if (issue_en) begin
      win_d   = issue_id;
      state_d = ISSUE;
    end else if (state_q == WAIT && apu_rvalid_i) begin
      state_d = IDLE;
    end
  end

  assign sel            = issue_en ? payload[issue_id] : '0;
  assign apu_req_o      = issue_en;
  assign apu_operands_o = sel.operands;
  assign apu_op_o       = sel.op;
  assign apu_flags_o    = sel.flags;
  assign rdata_o        = apu_rdata_i;
  assign rflags_o       = apu_rflags_i;
  assign err_o          = err_q;

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      win_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      win_q    <= win_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_fpu_apu_arbiter.sv
// Directed bench for fpu_apu_arbiter: a requester model, a latency-programmable FPU model,
// and a scoreboard monitor that checks every grant and every routed result.
module tb_fpu_apu_arbiter;
  import fpu_apu_arbiter_pkg::*;

  localparam int NB = 4;

  logic                     clk = 1'b0;
  logic                     rst_ni = 1'b0;
  logic [NB-1:0]            req_i, gnt_o, rvalid_o;
  logic [NB-1:0][2:0][31:0] operands_i;
  logic [NB-1:0][5:0]       op_i;
  logic [NB-1:0][14:0]      flags_i;
  logic [31:0]              rdata_o;
  logic [4:0]               rflags_o;
  logic                     apu_req_o, apu_gnt_i, apu_rvalid_i;
  logic [2:0][31:0]         apu_operands_o;
  logic [5:0]               apu_op_o;
  logic [14:0]              apu_flags_o;
  logic [31:0]              apu_rdata_i;
  logic [4:0]               apu_rflags_i;
  logic                     err_o;

  always #5 clk = ~clk;

  fpu_apu_arbiter dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .req_i          (req_i),
    .gnt_o          (gnt_o),
    .operands_i     (operands_i),
    .op_i           (op_i),
    .flags_i        (flags_i),
    .rvalid_o       (rvalid_o),
    .rdata_o        (rdata_o),
    .rflags_o       (rflags_o),
    .apu_req_o      (apu_req_o),
    .apu_gnt_i      (apu_gnt_i),
    .apu_operands_o (apu_operands_o),
    .apu_op_o       (apu_op_o),
    .apu_flags_o    (apu_flags_o),
    .apu_rvalid_i   (apu_rvalid_i),
    .apu_rdata_i    (apu_rdata_i),
    .apu_rflags_i   (apu_rflags_i),
    .err_o          (err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // FPU result: {status, data}, a fixed function of the payload it was handed.
  function automatic logic [36:0] fpu_fn(input logic [2:0][31:0] ops, input logic [5:0] op,
                                         input logic [14:0] fl);
    return {op[4:0] ^ fl[4:0], (ops[0] + ops[2]) ^ ops[1]};
  endfunction

  // Requester model: req stays high until as many grants as issued requests have been seen.
  int            issued  [NB] = '{default: 0};
  int            granted [NB] = '{default: 0};
  logic [NB-1:0] drv_g;

  always_comb begin
    req_i = '0;
    for (int k = 0; k < NB; k++) req_i[k] = (issued[k] != granted[k]);
  end

  initial begin
    forever begin
      @(negedge clk);
      drv_g = rst_ni ? gnt_o : '0;
      @(posedge clk);
      #1;
      for (int k = 0; k < NB; k++) begin
        if (!rst_ni) granted[k] = 0;
        else if (drv_g[k]) granted[k]++;
      end
    end
  end

  // FPU model: fixed latency after grant, or same-cycle response in zero-latency mode.
  logic        gnt_en  = 1'b1;
  logic        zl_mode = 1'b0;
  logic        spur_rv = 1'b0;
  int          fpu_lat = 3;
  logic        model_rv = 1'b0;
  logic [36:0] model_res = '0;
  logic [36:0] model_pend = '0;
  logic        m_busy = 1'b0;
  int          m_cnt = 0;
  logic        zl_fire;
  logic [36:0] zl_res;

  assign apu_gnt_i    = gnt_en;
  assign zl_fire      = zl_mode && gnt_en && (|req_i);
  assign zl_res       = fpu_fn(apu_operands_o, apu_op_o, apu_flags_o);
  assign apu_rvalid_i = model_rv | spur_rv | zl_fire;
  assign apu_rdata_i  = zl_fire ? zl_res[31:0]  : model_rv ? model_res[31:0]  : 32'hDEAD_BEEF;
  assign apu_rflags_i = zl_fire ? zl_res[36:32] : model_rv ? model_res[36:32] : 5'h1F;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_ni && apu_req_o && apu_gnt_i && !zl_mode) begin
        m_busy     = 1'b1;
        m_cnt      = fpu_lat;
        model_pend = fpu_fn(apu_operands_o, apu_op_o, apu_flags_o);
      end
      @(posedge clk);
      #1;
      model_rv = 1'b0;
      if (!rst_ni) begin
        m_busy = 1'b0;
      end else if (m_busy) begin
        m_cnt--;
        if (m_cnt <= 0) begin
          model_rv  = 1'b1;
          model_res = model_pend;
          m_busy    = 1'b0;
        end
      end
    end
  end

  // Scoreboard: expectations are pushed by the stimulus, consumed by the monitor.
  typedef struct {
    int   id;
    logic b2b;
  } gnt_exp_t;

  typedef struct {
    int          id;
    logic [36:0] res;
    int          lat;
  } rsp_exp_t;

  gnt_exp_t exp_gnt [$];
  rsp_exp_t exp_rsp [$];
  int       gnt_cyc_q [$];
  int       cyc = 0;
  gnt_exp_t mon_ge;
  rsp_exp_t mon_re;

  always @(negedge clk) begin
    if (!rst_ni) begin
      gnt_cyc_q.delete();
    end else begin
      cyc++;
      if (gnt_o != '0) begin
        gnt_cyc_q.push_back(cyc);
        if (exp_gnt.size() == 0) begin
          check("gnt_unexpected", gnt_o, 0);
        end else begin
          mon_ge = exp_gnt.pop_front();
          check("gnt_id", gnt_o, 64'(1) << mon_ge.id);
          check("gnt_with_rvalid", rvalid_o != '0, mon_ge.b2b);
        end
      end
      if (rvalid_o != '0) begin
        if (exp_rsp.size() == 0) begin
          check("rvalid_unexpected", rvalid_o, 0);
        end else begin
          mon_re = exp_rsp.pop_front();
          check("rvalid_id", rvalid_o, 64'(1) << mon_re.id);
          check("rdata", rdata_o, mon_re.res[31:0]);
          check("rflags", rflags_o, mon_re.res[36:32]);
          if (gnt_cyc_q.size() > 0) check("latency", cyc - gnt_cyc_q.pop_front(), mon_re.lat);
          else check("rvalid_before_gnt", 1, 0);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_op(input int id, input logic b2b, input int lat);
    exp_gnt.push_back(gnt_exp_t'{id: id, b2b: b2b});
    exp_rsp.push_back(rsp_exp_t'{id: id, res: fpu_fn(operands_i[id], op_i[id], flags_i[id]), lat: lat});
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (exp_gnt.size() != 0 || exp_rsp.size() != 0); i++) tick();
    tick(2);
    check("drain_gnt_left", exp_gnt.size(), 0);
    check("drain_rsp_left", exp_rsp.size(), 0);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    for (int k = 0; k < NB; k++) issued[k] = 0;
    tick(2);
    rst_ni = 1'b1;
    tick(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NB; k++) begin
      for (int j = 0; j < 3; j++)
        operands_i[k][j] = {8'(k + 1), 8'(j + 1), 16'(16'hA5C3 + k * 16'h0101 + j)};
      op_i[k]    = 6'(k * 5 + 3);
      flags_i[k] = 15'(k * 15'h0123 + 15'h11);
    end

    // Reset state
    @(negedge clk);
    check("rst_gnt", gnt_o, 0);
    check("rst_rvalid", rvalid_o, 0);
    check("rst_apu_req", apu_req_o, 0);
    check("rst_err", err_o, 0);
    check("rst_apu_op", apu_op_o, 0);
    check("rst_apu_operands_zero", apu_operands_o == '0, 1);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    tick(1);

    // Single request from requester 2, latency 3
    fpu_lat = 3;
    expect_op(2, 1'b0, 3);
    issued[2]++;
    drain();
    check("rr_ptr_after_single", dut.rr_ptr_q, 3);

    // All four requesting, latency 2: order 0,1,2,3,0, back-to-back after the first
    do_reset();
    fpu_lat = 2;
    expect_op(0, 1'b0, 2);
    expect_op(1, 1'b1, 2);
    expect_op(2, 1'b1, 2);
    expect_op(3, 1'b1, 2);
    expect_op(0, 1'b1, 2);
    issued[0] += 2;
    issued[1]++;
    issued[2]++;
    issued[3]++;
    drain();

    // Stall in ISSUE: requester 1 locked, requester 0 arrives mid-stall
    gnt_en = 1'b0;
    expect_op(1, 1'b0, 2);
    expect_op(0, 1'b1, 2);
    issued[1]++;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) issued[0]++;
      @(negedge clk);
      check("stall_apu_op", apu_op_o, op_i[1]);
      check("stall_apu_req", apu_req_o, 1);
      check("stall_no_gnt", gnt_o, 0);
      tick();
    end
    gnt_en = 1'b1;
    drain();

    // Zero-latency FPU: grant and result in the same cycle for requester 2
    zl_mode = 1'b1;
    expect_op(2, 1'b1, 0);
    issued[2]++;
    tick();
    @(negedge clk);
    check("zl_state_idle", dut.state_q, IDLE);
    check("zl_apu_req_low", apu_req_o, 0);
    check("zl_no_err", err_o, 0);
    zl_mode = 1'b0;
    drain();

    // Spurious response while idle
    check("err_before_spur", err_o, 0);
    spur_rv = 1'b1;
    @(negedge clk);
    check("spur_no_rvalid", rvalid_o, 0);
    tick();
    spur_rv = 1'b0;
    @(negedge clk);
    check("err_set", err_o, 1);
    tick(3);
    @(negedge clk);
    check("err_sticky", err_o, 1);
    tick();

    // Reset while waiting on a long-latency result
    fpu_lat = 5;
    exp_gnt.push_back(gnt_exp_t'{id: 3, b2b: 1'b0});
    issued[3]++;
    tick(3);
    #2;
    rst_ni = 1'b0;
    for (int k = 0; k < NB; k++) issued[k] = 0;
    #1;
    check("midrst_state", dut.state_q, IDLE);
    check("midrst_gnt", gnt_o, 0);
    check("midrst_rvalid", rvalid_o, 0);
    check("midrst_apu_req", apu_req_o, 0);
    check("midrst_err", err_o, 0);
    check("midrst_gnt_consumed", exp_gnt.size(), 0);
    tick(2);
    fpu_lat = 1;
    rst_ni  = 1'b1;
    expect_op(0, 1'b0, 1);
    expect_op(2, 1'b1, 1);
    issued[0]++;
    issued[2]++;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
